upd1771c_cmd_seq: RTL and testbench
===================================

UPD1771C_CMD_SEQ -- requirements
Module: upd1771c_cmd_seq

Interface
REQ-001 Parameter DEPTH, default 8: command FIFO depth in bytes, a power of two, minimum 2.
REQ-002 Parameter HOLD_CYC, default 8: number of CKEN-qualified cycles DOUT is driven with STB high.
REQ-003 Parameter GAP_CYC, default 72: number of CKEN-qualified idle cycles after each byte before the next byte may start.
REQ-004 CLK  in  1  single clock; all state changes on its rising edge.
REQ-005 RES  in  1  reset, asynchronous, active-high.
REQ-006 CKEN  in  1  clock enable shared with upd1771c; the ALIGN, DRIVE and GAP states advance only when CKEN=1.
REQ-007 PHI2P  in  1  one-cycle PHI2 phase pulse from upd1771c.
REQ-008 WR_EN  in  1  host byte write strobe.
REQ-009 WR_DATA  in  8  host command byte.
REQ-010 FULL  out  1  FIFO count equals DEPTH.
REQ-011 BUSY  out  1  state is not IDLE, or the FIFO is not empty.
REQ-012 OVF  out  1  sticky flag: a write was dropped.
REQ-013 DOUT  out  8  byte presented to upd1771c PA_I; 0 when not in DRIVE.
REQ-014 STB  out  1  high for exactly the whole of DRIVE.

Function
REQ-015 A write SHALL be accepted when WR_EN=1 and FULL=0, independent of CKEN.
REQ-016 A write while FULL=1 SHALL be dropped and SHALL set OVF, including a write in the same cycle as a pop; FULL is evaluated before the pop.
REQ-017 The FSM states SHALL be IDLE, ALIGN, DRIVE and GAP.
REQ-018 IDLE->ALIGN SHALL occur on the first clock edge at which the FIFO is non-empty, independent of CKEN.
REQ-019 ALIGN->DRIVE SHALL occur on a cycle with CKEN=1 and PHI2P=1; on that edge the head byte is popped into DOUT and the hold counter is loaded.
REQ-020 DRIVE SHALL last exactly HOLD_CYC CKEN=1 cycles, then DRIVE->GAP.
REQ-021 GAP SHALL last exactly GAP_CYC CKEN=1 cycles, with DOUT=0 and STB=0; it then goes to ALIGN if the FIFO is non-empty, otherwise to IDLE.
REQ-022 Counter width SHALL be $clog2(max(HOLD_CYC,GAP_CYC)+1); counters count down and never wrap.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH, and the count SHALL be $clog2(DEPTH)+1 bits wide.
REQ-024 Bytes SHALL be delivered in write order with no loss except as described in REQ-016.
REQ-025 The minimum byte-to-byte spacing SHALL be HOLD_CYC+GAP_CYC CKEN cycles plus the PHI2 alignment wait.

Reset
REQ-026 While RES=1: the state SHALL be IDLE, the FIFO empty, DOUT=0, STB=0, FULL=0, BUSY=0, OVF=0, and all counters 0.
REQ-027 Reset asserted mid-DRIVE SHALL drop STB and DOUT asynchronously and discard every queued byte.
REQ-028 OVF SHALL be cleared only by reset, or by FLUSH when UPD1771C_CMD_SEQ_FLUSH_EN is defined.

Configuration
REQ-029 When UPD1771C_CMD_SEQ_FLUSH_EN is defined: input port FLUSH (1 bit) SHALL exist.
REQ-030 With UPD1771C_CMD_SEQ_FLUSH_EN defined: FLUSH=1 on an edge SHALL empty the FIFO and clear OVF, and SHALL move ALIGN to IDLE.
REQ-031 With UPD1771C_CMD_SEQ_FLUSH_EN defined: a DRIVE or GAP in progress SHALL complete normally; FLUSH has priority over a simultaneous write, which is dropped without setting OVF.
REQ-032 When UPD1771C_CMD_SEQ_FLUSH_EN is undefined: no FLUSH port SHALL exist and the FIFO SHALL be emptied only by transmission or reset.

Structure
REQ-033 Package upd1771c_pkg SHALL hold the FSM state enum upd1771c_seq_state_t and the default localparams for HOLD_CYC and GAP_CYC.
REQ-034 The FIFO SHALL be a sub-module upd1771c_cmd_fifo (parameter DEPTH; ports wr, rd, din, dout, full, empty, count); the sequencer FSM stays in the top module.

Verification
REQ-035 Scenario: CKEN=1, write 0x09 to an idle block, PHI2P pulsing every 4 cycles -> STB is high for 8 cycles with DOUT=0x09, then 72 cycles of GAP, then BUSY=0.
REQ-036 Scenario: write 0x01, 0x02, 0x03 back-to-back -> three DRIVE windows in order 0x01, 0x02, 0x03, with each STB rise at least 80 CKEN cycles after the previous one and each aligned to PHI2P.
REQ-037 Scenario: 9 writes with DEPTH=8 while stalled in ALIGN (PHI2P=0) -> FULL=1 after the 8th write, the 9th is dropped, OVF=1, and later 8 bytes are delivered.
REQ-038 Scenario: CKEN toggling 1/0 -> DRIVE spans 16 clocks and GAP spans 144 clocks.
REQ-039 Scenario: RES pulsed during the 4th DRIVE cycle with 2 bytes queued -> STB=0 and DOUT=0 immediately, and no further STB after release.
REQ-040 Scenario, with UPD1771C_CMD_SEQ_FLUSH_EN: FLUSH pulsed during DRIVE with 3 bytes queued and OVF=1 -> the current byte completes, OVF=0, the FIFO is empty, and the state is IDLE after GAP.

Source files
------------

// File: rtl/upd1771c_pkg.sv
// Shared types and defaults for the uPD1771C command sequencer.
package upd1771c_pkg;

  localparam int HOLD_CYC_DEF = 8;
  localparam int GAP_CYC_DEF  = 72;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_DRIVE = 2'd2,
    ST_GAP   = 2'd3
  } upd1771c_seq_state_t;

  function automatic int cnt_width(input int hold, input int gap);
    return $clog2(((hold > gap) ? hold : gap) + 1);
  endfunction

endpackage

// File: rtl/upd1771c_cmd_fifo.sv
// Byte FIFO feeding the sequencer; clr input exists only when UPD1771C_CMD_SEQ_FLUSH_EN is defined.
module upd1771c_cmd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef UPD1771C_CMD_SEQ_FLUSH_EN
  input  logic                   clr,
`endif
  input  logic                   wr,
  input  logic                   rd,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;
  logic          clear;

`ifdef UPD1771C_CMD_SEQ_FLUSH_EN
  assign clear = clr;
`else
  assign clear = 1'b0;
`endif

  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);
  // full is the pre-edge value, so a write coinciding with a pop on a full FIFO is dropped
  assign wr_ok = wr && !full && !clear;
  assign rd_ok = rd && !empty && !clear;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(wr_ok) - (AW + 1)'(rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/upd1771c_cmd_seq.sv
// Host-to-uPD1771C command byte sequencer: FIFO, PHI2 alignment, strobed hold and gap.
// Optional FLUSH input enabled by UPD1771C_CMD_SEQ_FLUSH_EN.
module upd1771c_cmd_seq
  import upd1771c_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int GAP_CYC  = GAP_CYC_DEF
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       CKEN,
  input  logic       PHI2P,
  input  logic       WR_EN,
  input  logic [7:0] WR_DATA,
`ifdef UPD1771C_CMD_SEQ_FLUSH_EN
  input  logic       FLUSH,
`endif
  output logic       FULL,
  output logic       BUSY,
  output logic       OVF,
  output logic [7:0] DOUT,
  output logic       STB
);

  localparam int CW = cnt_width(HOLD_CYC, GAP_CYC);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC);

  upd1771c_seq_state_t   state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [7:0]            data_reg, data_next;
  logic                  ovf_reg;
  logic                  pop;
  logic                  flush;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [7:0]            fifo_dout;
  logic [$clog2(DEPTH):0] fifo_count;

`ifdef UPD1771C_CMD_SEQ_FLUSH_EN
  assign flush = FLUSH;
`else
  assign flush = 1'b0;
`endif

  upd1771c_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RES),
`ifdef UPD1771C_CMD_SEQ_FLUSH_EN
    .clr   (flush),
`endif
    .wr    (WR_EN),
    .rd    (pop),
    .din   (WR_DATA),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      data_reg  <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      if (flush)                 ovf_reg <= 1'b0;
      else if (WR_EN && fifo_full) ovf_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty && !flush) state_next = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else if (CKEN && PHI2P) begin
          state_next = ST_DRIVE;
          pop        = 1'b1;
          data_next  = fifo_dout;
          cnt_next   = HOLD_LD;
        end
      end
      ST_DRIVE: begin
        if (CKEN) begin
          if (cnt_reg <= CW'(1)) begin
            state_next = ST_GAP;
            cnt_next   = GAP_LD;
            data_next  = '0;
          end else begin
            cnt_next = cnt_reg - CW'(1);
          end
        end
      end
      ST_GAP: begin
        if (CKEN) begin
          if (cnt_reg <= CW'(1)) begin
            state_next = (fifo_empty || flush) ? ST_IDLE : ST_ALIGN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - CW'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign STB  = (state_reg == ST_DRIVE);
  assign DOUT = STB ? data_reg : 8'h00;
  assign FULL = fifo_full;
  assign OVF  = ovf_reg;
  assign BUSY = (state_reg != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_upd1771c_cmd_seq.sv
// Self-checking bench for upd1771c_cmd_seq with a queue-based reference model.
module tb_upd1771c_cmd_seq;

  localparam int DEPTH = 8;
  localparam int HOLD  = 8;
  localparam int GAP   = 72;

  logic       CLK = 1'b0;
  logic       RES;
  logic       CKEN;
  logic       PHI2P;
  logic       WR_EN;
  logic [7:0] WR_DATA;
  logic       FULL;
  logic       BUSY;
  logic       OVF;
  logic [7:0] DOUT;
  logic       STB;
`ifdef UPD1771C_CMD_SEQ_FLUSH_EN
  logic       FLUSH;
`endif

  always #5 CLK = ~CLK;

  upd1771c_cmd_seq #(.DEPTH(DEPTH), .HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut (
    .CLK     (CLK),
    .RES     (RES),
    .CKEN    (CKEN),
    .PHI2P   (PHI2P),
    .WR_EN   (WR_EN),
    .WR_DATA (WR_DATA),
`ifdef UPD1771C_CMD_SEQ_FLUSH_EN
    .FLUSH   (FLUSH),
`endif
    .FULL    (FULL),
    .BUSY    (BUSY),
    .OVF     (OVF),
    .DOUT    (DOUT),
    .STB     (STB)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: queued bytes plus remaining hold/gap CKEN cycles
  logic [7:0] q[$];
  int         m_drive, m_gap;
  bit         m_align, m_ovf;
  logic [7:0] m_cur;

  // observation bookkeeping
  int         rises, stb_clk, post_busy, cken_since;
  logic [7:0] rise_log[$];
  logic       stb_prev;
  bit         edge_aligned;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_drive = 0;
    m_gap   = 0;
    m_align = 0;
    m_ovf   = 0;
    m_cur   = '0;
  endtask

  task automatic model_edge(bit fl);
    int sz;
    bit acc;
    sz  = q.size();
    acc = WR_EN && !fl && (sz < DEPTH);
    if (m_drive > 0) begin
      if (CKEN) begin
        m_drive--;
        if (m_drive == 0) m_gap = GAP;
      end
    end else if (m_gap > 0) begin
      if (CKEN) begin
        m_gap--;
        if (m_gap == 0) m_align = (sz > 0) && !fl;
      end
    end else if (m_align) begin
      if (fl) m_align = 0;
      else if (CKEN && PHI2P) begin
        m_cur   = q.pop_front();
        m_drive = HOLD;
        m_align = 0;
      end
    end else if (sz > 0 && !fl) begin
      m_align = 1;
    end
    if (fl) begin
      q.delete();
      m_ovf = 0;
    end else if (WR_EN && !acc) begin
      m_ovf = 1;
    end
    if (acc) q.push_back(WR_DATA);
  endtask

  task automatic check_all();
    check("stb",  STB,  (m_drive > 0));
    check("dout", DOUT, (m_drive > 0) ? 32'(m_cur) : 32'd0);
    check("full", FULL, (q.size() == DEPTH));
    check("busy", BUSY, (q.size() > 0) || (m_drive > 0) || (m_gap > 0) || m_align);
    check("ovf",  OVF,  m_ovf);
  endtask

  task automatic cycle();
    bit fl;
    fl = 0;
`ifdef UPD1771C_CMD_SEQ_FLUSH_EN
    fl = FLUSH;
`endif
    @(posedge CLK);
    edge_aligned = CKEN && PHI2P;
    if (CKEN) cken_since++;
    if (RES) model_reset();
    else     model_edge(fl);
    cyc++;
    #1;
    check_all();
    if (STB && !stb_prev) begin
      rises++;
      rise_log.push_back(DOUT);
      check("phi2_align", edge_aligned, 1);
      if (rises > 1) check("spacing", (cken_since >= HOLD + GAP), 1);
      cken_since = 0;
    end
    if (STB) stb_clk++;
    if (!STB && BUSY && rises > 0) post_busy++;
    stb_prev = STB;
  endtask

  task automatic drive_mode(int mode);
    case (mode)
      0:       begin CKEN = 1'b1; PHI2P = (cyc % 4 == 3); end
      1:       begin CKEN = ($urandom_range(3) != 0); PHI2P = ($urandom_range(2) == 0); end
      2:       begin CKEN = (cyc % 2 == 0); PHI2P = (cyc % 4 == 0); end
      default: begin CKEN = 1'b1; PHI2P = 1'b0; end
    endcase
  endtask

  task automatic write_byte(logic [7:0] d, int mode);
    drive_mode(mode);
    WR_EN   = 1'b1;
    WR_DATA = d;
    cycle();
    WR_EN   = 1'b0;
  endtask

  task automatic run_until_idle(int maxc, int mode);
    for (int i = 0; i < maxc; i++) begin
      drive_mode(mode);
      cycle();
      if (!BUSY) break;
    end
    check("idle_timeout", BUSY, 0);
  endtask

  task automatic clear_obs();
    rises = 0; stb_clk = 0; post_busy = 0; cken_since = 0;
    rise_log.delete();
  endtask

  initial begin
    logic [7:0] exp_b[$];
    RES = 1'b1; CKEN = 1'b0; PHI2P = 1'b0; WR_EN = 1'b0; WR_DATA = '0;
`ifdef UPD1771C_CMD_SEQ_FLUSH_EN
    FLUSH = 1'b0;
`endif
    model_reset();
    stb_prev = 1'b0;
    clear_obs();
    repeat (3) cycle();
    RES = 1'b0;

    // single byte, steady CKEN
    clear_obs();
    write_byte(8'h09, 0);
    run_until_idle(300, 0);
    check("s1_rises", rises, 1);
    check("s1_byte", (rise_log.size() > 0) ? 32'(rise_log[0]) : 32'hFFFF, 32'h09);
    check("s1_stb_clocks", stb_clk, HOLD);
    check("s1_gap_clocks", post_busy, GAP);

    // three back-to-back bytes, random CKEN/PHI2P
    clear_obs();
    write_byte(8'h01, 1);
    write_byte(8'h02, 1);
    write_byte(8'h03, 1);
    run_until_idle(3000, 1);
    check("s2_rises", rises, 3);
    for (int i = 0; i < 3; i++)
      if (i < rise_log.size()) check("s2_order", rise_log[i], 32'(i + 1));

    // stall in ALIGN and overflow
    clear_obs();
    exp_b.delete();
    for (int i = 0; i < 9; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if (i < 8) exp_b.push_back(d);
      write_byte(d, 3);
      if (i == 7) check("s3_full_after_8", FULL, 1);
    end
    check("s3_ovf", OVF, 1);
    run_until_idle(3000, 0);
    check("s3_rises", rises, 8);
    for (int i = 0; i < 8; i++)
      if (i < rise_log.size()) check("s3_order", rise_log[i], exp_b[i]);

    // CKEN toggling stretches DRIVE and GAP in clocks
    clear_obs();
    write_byte(8'h5A, 2);
    run_until_idle(600, 2);
    check("s4_stb_clocks", stb_clk, 2 * HOLD);
    check("s4_gap_clocks", post_busy, 2 * GAP);

    // random traffic
    clear_obs();
    for (int i = 0; i < 800; i++) begin
      drive_mode(1);
      WR_EN   = ($urandom_range(5) == 0);
      WR_DATA = 8'($urandom);
      cycle();
    end
    WR_EN = 1'b0;
    run_until_idle(6000, 1);

    // reset during the 4th DRIVE cycle with 2 bytes queued
    clear_obs();
    write_byte(8'hA1, 3);
    write_byte(8'hA2, 3);
    write_byte(8'hA3, 3);
    for (int i = 0; i < 50 && !STB; i++) begin
      drive_mode(0);
      cycle();
    end
    check("s5_stb_seen", STB, 1);
    repeat (3) cycle();
    #2;
    RES = 1'b1;
    #1;
    check("s5_async_stb", STB, 0);
    check("s5_async_dout", DOUT, 0);
    check("s5_async_busy", BUSY, 0);
    check("s5_async_full", FULL, 0);
    model_reset();
    repeat (2) cycle();
    RES = 1'b0;
    clear_obs();
    for (int i = 0; i < 200; i++) begin
      drive_mode(0);
      cycle();
    end
    check("s5_no_stb", rises, 0);

`ifdef UPD1771C_CMD_SEQ_FLUSH_EN
    // flush during DRIVE with OVF set
    clear_obs();
    for (int i = 0; i < 9; i++) write_byte(8'(8'h30 + i), 3);
    check("s6_ovf_set", OVF, 1);
    for (int i = 0; i < 50 && !STB; i++) begin
      drive_mode(0);
      cycle();
    end
    drive_mode(0);
    cycle();
    FLUSH   = 1'b1;
    WR_EN   = 1'b1;
    WR_DATA = 8'hEE;
    cycle();
    FLUSH = 1'b0;
    WR_EN = 1'b0;
    check("s6_ovf_clear", OVF, 0);
    check("s6_stb_kept", STB, 1);
    run_until_idle(400, 0);
    check("s6_rises", rises, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
